// File: rtl/rob_axi_pkg.sv
// ----------------------------------------------------------------------------
// rob_axi_pkg
//   Shared AXI definitions for the ROB <-> AXI slave request and response
//   paths. Holds the default field widths used by both the outgoing AR buffer
//   and the incoming R buffer, plus the packed AR request record.
//
//   No ports (package).
// ----------------------------------------------------------------------------
package rob_axi_pkg;

    // Default AXI field widths, shared by the AR and R paths.
    localparam int AXI_ID_WIDTH    = 4;
    localparam int AXI_ADDR_WIDTH  = 32;
    localparam int AXI_LEN_WIDTH   = 8;
    localparam int AXI_SIZE_WIDTH  = 3;
    localparam int AXI_BURST_WIDTH = 2;
    localparam int AXI_DATA_WIDTH  = 64;

    // One AR request at the default widths.
    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]    id;
        logic [AXI_ADDR_WIDTH-1:0]  addr;
        logic [AXI_LEN_WIDTH-1:0]   len;
        logic [AXI_SIZE_WIDTH-1:0]  size;
        logic [AXI_BURST_WIDTH-1:0] burst;
    } ar_entry_t;

endpackage : rob_axi_pkg

// File: rtl/ar_outstanding_ctr.sv
// ----------------------------------------------------------------------------
// ar_outstanding_ctr
//   Tracks the number of AR bursts issued to the slave whose last R beat has
//   not yet come back. Raises at_limit_o when the count reaches
//   MAX_OUTSTANDING so the caller can stop issuing. A completion seen while
//   nothing is outstanding leaves the count at 0 and sets a sticky error.
//
//   Ports:
//     clk             clock
//     rst             asynchronous active-high reset
//     inc_i           one AR issued this cycle
//     dec_i           one burst completed this cycle (R beat with last=1)
//     cnt_o           bursts currently in flight
//     at_limit_o      cnt_o == MAX_OUTSTANDING
//     err_underflow_o sticky: dec_i seen with cnt_o == 0 and no inc_i
// ----------------------------------------------------------------------------
module ar_outstanding_ctr #(
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 inc_i,
    input  logic                                 dec_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] cnt_o,
    output logic                                 at_limit_o,
    output logic                                 err_underflow_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // NOTE: every output of a combinational block gets a default on entry;
    // a path that skips an assignment would otherwise infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (inc_i & ~dec_i) begin
            // The caller never issues while at_limit_o is high, so no overflow.
            cnt_d = cnt_q + CNT_ONE;
        end else if (dec_i & ~inc_i) begin
            if (cnt_q == '0) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge value of its sources, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign cnt_o           = cnt_q;
    assign at_limit_o      = (cnt_q == CNT_MAX);
    assign err_underflow_o = err_q;

endmodule : ar_outstanding_ctr

// File: rtl/outgoing_ar_buffer.sv
// ----------------------------------------------------------------------------
// outgoing_ar_buffer
//   DEPTH-entry registered FIFO carrying AXI AR requests from the ROB request
//   side toward the AXI slave. Storage is registered (no fall-through): a
//   request pushed in cycle N is first offered on ar_out in cycle N+1, and
//   the buffer sustains one request per cycle.
//
//   Optional macro OUTSTANDING_LIMIT_EN:
//     defined   - counts issued-but-incomplete bursts (up on each AR issued,
//                 down on each r_done_i pulse) and withholds ar_out_valid_o
//                 while MAX_OUTSTANDING bursts are in flight.
//     undefined - no tracker; ar_out_valid_o = ~empty, r_done_i is ignored,
//                 outstanding_cnt_o and err_underflow_o are tied to 0.
//
//   Ports:
//     clk, rst            clock, asynchronous active-high reset
//     ar_in_*             AR from request side (valid_i/ready_o + payload _i)
//     ar_out_*            AR toward slave (valid_o/ready_i + payload _o);
//                         payload always shows the head entry, don't-care
//                         while ar_out_valid_o is low
//     r_done_i            one-cycle pulse per accepted R beat with last=1
//     fifo_count_o        current FIFO occupancy
//     outstanding_cnt_o   bursts in flight
//     err_underflow_o     sticky: r_done_i seen with nothing outstanding
// ----------------------------------------------------------------------------
module outgoing_ar_buffer
    import rob_axi_pkg::*;
#(
    parameter int ID_WIDTH        = AXI_ID_WIDTH,
    parameter int ADDR_WIDTH      = AXI_ADDR_WIDTH,
    parameter int LEN_WIDTH       = AXI_LEN_WIDTH,
    parameter int SIZE_WIDTH      = AXI_SIZE_WIDTH,
    parameter int BURST_WIDTH     = AXI_BURST_WIDTH,
    parameter int DEPTH           = 8,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,

    input  logic                                 ar_in_valid_i,
    output logic                                 ar_in_ready_o,
    input  logic [ID_WIDTH-1:0]                  ar_in_id_i,
    input  logic [ADDR_WIDTH-1:0]                ar_in_addr_i,
    input  logic [LEN_WIDTH-1:0]                 ar_in_len_i,
    input  logic [SIZE_WIDTH-1:0]                ar_in_size_i,
    input  logic [BURST_WIDTH-1:0]               ar_in_burst_i,

    output logic                                 ar_out_valid_o,
    input  logic                                 ar_out_ready_i,
    output logic [ID_WIDTH-1:0]                  ar_out_id_o,
    output logic [ADDR_WIDTH-1:0]                ar_out_addr_o,
    output logic [LEN_WIDTH-1:0]                 ar_out_len_o,
    output logic [SIZE_WIDTH-1:0]                ar_out_size_o,
    output logic [BURST_WIDTH-1:0]               ar_out_burst_o,

    input  logic                                 r_done_i,
    output logic [$clog2(DEPTH+1)-1:0]           fifo_count_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_cnt_o,
    output logic                                 err_underflow_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    // Storage record at this instance's widths (ar_entry_t is the
    // default-width view of the same layout).
    typedef struct packed {
        logic [ID_WIDTH-1:0]    id;
        logic [ADDR_WIDTH-1:0]  addr;
        logic [LEN_WIDTH-1:0]   len;
        logic [SIZE_WIDTH-1:0]  size;
        logic [BURST_WIDTH-1:0] burst;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           entry_in;
    entry_t           head;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic             full;
    logic             empty;
    logic             out_valid;
    logic             push;
    logic             pop;

    // Wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        if (p == PTR_LAST) begin
            return '0;
        end
        return p + PTR_ONE;
    endfunction

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);

    // Ready is deliberately not pop-aware: a full FIFO refuses a push even
    // when the head leaves in the same cycle.
    assign ar_in_ready_o = ~full;
    assign push          = ar_in_valid_i & ~full;
    assign pop           = out_valid & ar_out_ready_i;

    assign entry_in = '{
        id:    ar_in_id_i,
        addr:  ar_in_addr_i,
        len:   ar_in_len_i,
        size:  ar_in_size_i,
        burst: ar_in_burst_i
    };

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = ptr_next(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end
        if (push & ~pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop & ~push) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the entry array is left unreset; an entry is only read after it
    // has been written, and the pointer/count reset already discards it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= entry_in;
        end
    end

    // Head entry drives the payload continuously; it only moves on a pop, so
    // the payload is stable while valid waits for ready.
    assign head           = mem_q[rd_ptr_q];
    assign ar_out_id_o    = head.id;
    assign ar_out_addr_o  = head.addr;
    assign ar_out_len_o   = head.len;
    assign ar_out_size_o  = head.size;
    assign ar_out_burst_o = head.burst;
    assign ar_out_valid_o = out_valid;
    assign fifo_count_o   = count_q;

`ifdef OUTSTANDING_LIMIT_EN
    logic at_limit;

    // The count can only fall when no pop occurs, so once valid is raised
    // it cannot be withdrawn before the handshake completes.
    ar_outstanding_ctr #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_outstanding_ctr (
        .clk             (clk),
        .rst             (rst),
        .inc_i           (pop),
        .dec_i           (r_done_i),
        .cnt_o           (outstanding_cnt_o),
        .at_limit_o      (at_limit),
        .err_underflow_o (err_underflow_o)
    );

    assign out_valid = ~empty & ~at_limit;
`else
    logic unused_r_done;

    assign unused_r_done     = r_done_i;
    assign out_valid         = ~empty;
    assign outstanding_cnt_o = '0;
    assign err_underflow_o   = 1'b0;
`endif

endmodule : outgoing_ar_buffer

// File: doc/outgoing_ar_buffer.md
Name: outgoing_ar_buffer

Overview:
- 8-entry FIFO for AXI AR (read address) requests, travelling from the ROB request side toward the AXI slave. It is the request-direction counterpart of the incoming R response buffer.
- Enforces a cap on outstanding reads. The count goes up on each AR issued to the slave and down on each R beat returned with last=1.
- This keeps the number of in-flight bursts bounded so that the response path and reorder storage cannot overflow.

Parameters:
- ID_WIDTH, 4, AR ID width
- ADDR_WIDTH, 32, AR address width
- LEN_WIDTH, 8, ARLEN width
- SIZE_WIDTH, 3, ARSIZE width
- BURST_WIDTH, 2, ARBURST width
- DEPTH, 8, FIFO entries (>=2)
- MAX_OUTSTANDING, 16, maximum issued-but-incomplete bursts (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ar_in  ar_if.receiver  —  AR from request side (valid, ready, id, addr, len, size, burst)
- ar_out  ar_if.sender  —  AR toward AXI slave (same fields)
- r_done  in  1  one-cycle pulse per accepted slave R beat with last=1
- fifo_count  out  $clog2(DEPTH+1)  current FIFO occupancy
- outstanding_cnt  out  $clog2(MAX_OUTSTANDING+1)  in-flight bursts
- err_underflow  out  1  sticky: r_done seen with outstanding_cnt==0

Behaviour:
- Reset values:
  - wr/rd pointers 0; fifo_count 0; outstanding_cnt 0; err_underflow 0.
  - ar_in.ready=1; ar_out.valid=0.
- ar_in.ready = ~full. push = ar_in.valid & ar_in.ready.
- ar_out.valid = ~empty & (outstanding_cnt < MAX_OUTSTANDING). pop = ar_out.valid & ar_out.ready.
- ar_out fields always reflect the head entry (mem[rd_ptr]). They are don't-care when ar_out.valid=0.
- Latency:
  - Registered storage, no fall-through: a beat pushed in cycle N is first visible on ar_out in cycle N+1.
  - Throughput is 1 request per cycle.
- Pointer wrap: after DEPTH-1, the pointer returns to 0 (DEPTH need not be a power of 2).
- fifo_count:
  - push only: +1.
  - pop only: -1.
  - Both or neither: unchanged.
- Full: ar_in.ready=0 and no push; a pop in the same cycle does not enable a push (ready is not pop-aware).
- Empty with simultaneous push: no pop (valid=0); the entry appears next cycle.
- outstanding_cnt:
  - pop & ~r_done: +1.
  - r_done & ~pop: -1.
  - Both: unchanged.
  - Never exceeds MAX_OUTSTANDING, since pop is gated by the limit.
- Underflow: r_done while outstanding_cnt==0 and no pop → count stays 0 and err_underflow is set to 1 until reset.
- AXI stability: once ar_out.valid=1, it stays 1 with a stable payload until pop. Reason: outstanding_cnt can only fall while no pop occurs, and the head cannot change without a pop.
- Reset mid-operation: all queued requests are discarded, counters clear, and outputs return to reset values asynchronously.
- All control uses bitwise &, |, ~ only.

Optional Feature:
- Macro: OUTSTANDING_LIMIT_EN
- Defined: outstanding tracking and gating exactly as above.
- Undefined:
  - ar_out.valid = ~empty.
  - No tracker logic; r_done is ignored.
  - outstanding_cnt tied to 0; err_underflow tied to 0.

Decomposition:
- Package rob_axi_pkg holds:
  - ar_entry_t packed struct {id, addr, len, size, burst}.
  - Default width localparams shared with the R path.
- Sub-module ar_outstanding_ctr:
  - Inputs: inc (=pop), dec (=r_done).
  - Outputs: cnt, at_limit, err_underflow.
  - Instantiated only under OUTSTANDING_LIMIT_EN.

Test Plan:
- Reset, then push 1 AR (id=3, addr=0x1000, len=7) with ar_out.ready=1 → ar_out.valid the next cycle with identical fields; outstanding_cnt goes 0→1 after the pop.
- 8 pushes with ar_out.ready=0 → fifo_count=8, ar_in.ready=0; 9th push is held off; one pop → ar_in.ready=1 the following cycle.
- 12 pushes with interleaved pops, ids 0..11 → output order 0..11; pointer wrap exercised; fifo_count returns to 0.
- Outstanding limit, MAX_OUTSTANDING=16, 17 requests, no r_done:
  - 16 issued, ar_out.valid=0 for the 17th.
  - One r_done pulse → 17th issued within 1 cycle.
  - outstanding_cnt stays 16.
- Same cycle pop & r_done at outstanding_cnt=5 → remains 5. r_done with count=0 → err_underflow=1 and stays set.
- Assert rst while fifo_count=4 and outstanding_cnt=3 → all outputs return to reset values immediately; post-reset push works normally.
